// File: rtl/serial_adder_fsm.sv
// serial_adder_fsm: bit-serial LSB-first adder with start/done handshake; define SERIAL_SUB_EN for a sub (a-b) input.
module serial_adder_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b, res;
  logic [CW-1:0] cnt;
  logic carry, s, last, sub_i;
`ifdef SERIAL_SUB_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b0;
`endif
  assign s = sh_a[0] ^ sh_b[0] ^ carry;
  assign last = cnt == CW'(WIDTH - 1);
  always_comb begin
    state_nxt = state == IDLE  ? (start ? SHIFT : IDLE) :
                state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
  end
  // Subtraction is a + ~b + 1, so the carry flop doubles as not-borrow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      sh_a  <= '0;
      sh_b  <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= state_nxt != IDLE;
      done  <= state == DONE;
      if (state == IDLE && start) begin
        sh_a  <= a;
        sh_b  <= b ^ {WIDTH{sub_i}};
        carry <= sub_i;
        cnt   <= '0;
      end else if (state == SHIFT) begin
        sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
        sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
        carry <= (sh_a[0] & sh_b[0]) | (carry & (sh_a[0] ^ sh_b[0]));
        res   <= {s, res[WIDTH-1:1]};
        cnt   <= cnt + 1'b1;
      end else if (state == DONE) begin
        sum  <= res;
        cout <= carry;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_fsm.sv
// tb_serial_adder_fsm: table-driven and sequence checks of serial_adder_fsm with an expected-result queue.
module tb_serial_adder_fsm;
  localparam int WIDTH = 8;
  logic clk = 0, rst = 1, start = 0, sub = 0;
  logic [WIDTH-1:0] a = 0, b = 0, sum;
  logic busy, done, cout;
  int tests = 0, fails = 0;
  typedef struct { logic [7:0] s; logic c; } exp_t;
  typedef struct { logic [7:0] a; logic [7:0] b; logic sb; logic [7:0] s; logic c; } vec_t;
  exp_t q[$];
  vec_t vecs[$];

  serial_adder_fsm #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef SERIAL_SUB_EN
    .sub(sub),
`endif
    .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_chk(input string name);
    exp_t e;
    if (q.size() == 0) begin
      chk({name, "_queue"}, 0, 1);
      return;
    end
    e = q.pop_front();
    chk({name, "_sum"}, 32'(sum), 32'(e.s));
    chk({name, "_cout"}, 32'(cout), 32'(e.c));
  endtask

  task automatic op(input logic [7:0] x, input logic [7:0] y, input logic sb,
                    input logic [7:0] es, input logic ec, input logic hold);
    int n;
    exp_t e;
    e.s = es;
    e.c = ec;
    @(negedge clk);
    a = x; b = y; sub = sb; start = 1;
    q.push_back(e);
    n = 0;
    @(posedge clk); n++;
    @(negedge clk);
    chk("busy_after_start", 32'(busy), 1);
    if (hold) begin a = 8'hAA; b = 8'h55; end
    else start = 0;
    while (!done && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
    start = 0;
    chk("latency_edges", n, WIDTH + 2);
    pop_chk("result");
    @(posedge clk);
    @(negedge clk);
    chk("done_single", 32'(done), 0);
    chk("idle_after", 32'(busy), 0);
    chk("held_sum", 32'(sum), 32'(es));
  endtask

  initial begin
    int ndone, last_edge;
    vecs.push_back('{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1});
`ifdef SERIAL_SUB_EN
    vecs.push_back('{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0});
    vecs.push_back('{8'h07, 8'h05, 1'b1, 8'h02, 1'b1});
    vecs.push_back('{8'h33, 8'h33, 1'b1, 8'h00, 1'b1});
`endif
    vecs.push_back('{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0});
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);
    rst = 0;
    foreach (vecs[i]) op(vecs[i].a, vecs[i].b, vecs[i].sb, vecs[i].s, vecs[i].c, 1'b0);
    op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b1);
    // Abort mid-operation: sum is 0x30 beforehand, so the clear is observable.
    @(negedge clk);
    a = 8'h80; b = 8'h80; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_sum", 32'(sum), 0);
    chk("abort_cout", 32'(cout), 0);
    @(negedge clk);
    rst = 0;
    op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0);
    // Back-to-back with start held: done every WIDTH+2 edges.
    @(negedge clk);
    a = 8'h12; b = 8'h34; sub = 0; start = 1;
    repeat (3) q.push_back('{8'h46, 1'b0});
    ndone = 0;
    last_edge = 0;
    for (int e = 1; e <= 3 * (WIDTH + 2); e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("b2b_period", e - last_edge, WIDTH + 2);
        last_edge = e;
        pop_chk("b2b");
      end
    end
    start = 0;
    chk("b2b_count", ndone, 3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_adder_fsm.md
Name: serial_adder_fsm

Overview:
- Bit-serial ripple adder with start/done handshake. It is the addition counterpart of the half-subtractor arithmetic blocks.
- Processes one bit pair per clock, LSB first, through a single full-adder cell and a carry flop.
- Used where area matters more than latency. Also serves as a sequential reference for the combinational adder/subtractor family.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- done  output  1  one-cycle pulse; sum/cout valid.
- sum  output  WIDTH  result a+b mod 2^WIDTH.
- cout  output  1  carry out of MSB.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry flop and bit counter all cleared.
- States: IDLE, SHIFT, DONE. The state register width is the minimum needed.
- IDLE:
  - If start=1: load sh_a<=a, sh_b<=b, carry<=0, cnt<=0, go to SHIFT.
  - Otherwise hold. sum/cout keep the last result.
- SHIFT, each cycle:
  - s = sh_a[0]^sh_b[0]^carry.
  - carry <= majority(sh_a[0], sh_b[0], carry).
  - sh_a and sh_b shift right by 1.
  - Result register shifts right with s entering at the MSB.
  - cnt++.
  - When cnt==WIDTH-1 this cycle: go to DONE.
- DONE (one cycle):
  - sum <= result register; cout <= carry.
  - done=1, then go to IDLE.
  - sum/cout become valid in this cycle and are held until the next accepted start completes.
- Latency: start sampled at edge N gives done=1 in the cycle after edge N+WIDTH+1, i.e. WIDTH+2 edges from request to visible done.
- Throughput: one operation per WIDTH+2 cycles. start=1 in the DONE cycle is ignored; start is accepted again in IDLE.
- start asserted while busy: ignored, no effect on in-flight operands. a/b may change freely after acceptance.
- Reset mid-operation: aborts immediately. All outputs return to reset values and the partial result is discarded.
- cnt width is clog2(WIDTH). No arithmetic wider than 1 bit outside the counter.
- busy and done are registered outputs, with no combinational path from inputs.

Optional Feature:
- Macro: SERIAL_SUB_EN.
- Defined:
  - Adds port `sub  input  1`, captured with start.
  - When sub=1: sh_b loads ~b and carry initialises to 1, so sum = a-b mod 2^WIDTH.
  - cout is then the not-borrow flag: 1 when a>=b unsigned.
  - When sub=0: behaviour is identical to the adder.
- Undefined:
  - No sub port; addition only. Timing and handshake are unchanged.

Test Plan:
- WIDTH=8, a=0x35, b=0x4A, start pulse -> busy high next cycle; done pulse exactly WIDTH+2 edges after start; sum=0x7F, cout=0.
- a=0xFF, b=0x01 -> sum=0x00, cout=1. Then a=0x00, b=0x00 -> sum=0x00, cout=0. Previous result held between operations.
- Start a=0x10, b=0x20; hold start=1 and change a=0xAA, b=0x55 during SHIFT -> single done, sum=0x30. No second operation until IDLE.
- Start a=0x80, b=0x80; assert rst after 3 SHIFT cycles -> busy=0, done=0, sum=0, cout=0 immediately. A fresh start afterwards gives sum=0x00, cout=1.
- Back-to-back: start held high continuously -> operations complete every WIDTH+2 cycles, one done per operation.
- SERIAL_SUB_EN defined, sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0. a=0x07, b=0x05 -> sum=0x02, cout=1.
